// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decoded ID-side instruction going in, registered EX-side
// copy, the load-use stall request and the stall counter coming out.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    // ID side (driven by decode / control unit)
    logic [13:0]       id_ctrl;
    logic              id_valid;
    logic [DATA_W-1:0] id_pc4;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [5:0]        id_funct;
    logic              flush;

    // EX side (driven by the pipeline register)
    logic [13:0]       ex_ctrl;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc4;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [5:0]        ex_funct;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    // Upstream view: decode drives ID fields and observes EX state and stall
    modport master (
        output id_ctrl, id_valid, id_pc4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_funct, flush,
        input  ex_ctrl, ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_funct, stall, stall_cnt
    );

    // Pipeline-register view
    modport slave (
        input  id_ctrl, id_valid, id_pc4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_funct, flush,
        output ex_ctrl, ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_funct, stall, stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection. A load in EX whose
// destination matches a source of the ID instruction stalls PC and IF/ID for
// one cycle and sends a bubble into EX; a flush also sends a bubble. Stall
// cycles are counted in a saturating counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic   clk,
    input logic   rst_n,
    id_ex_if.slave bus
);
    // Control word packing:
    // {RegDst,Jump[1:0],Branch[1:0],MemRead[1:0],MemtoReg,ALUOp[1:0],MemWrite[1:0],ALUSrc,RegWrite}
    localparam int MEMREAD_HI = 8;
    localparam int MEMREAD_LO = 7;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Operand and index fields travel together and always load from ID.
    typedef struct packed {
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [5:0]        funct;
    } payload_t;

    logic [13:0]      ex_ctrl_q,   ex_ctrl_d;
    logic             ex_valid_q,  ex_valid_d;
    payload_t         payload_q,   payload_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic bubble;
    logic stall;

    // Hazard detection and next-state selection for the pipeline register.
    // The rt match is made even for I-types, whose rt is a destination; that
    // costs an occasional needless stall but never misses a real hazard.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
        load_use    = 1'b0;
        bubble      = 1'b0;
        stall       = 1'b0;
        ex_ctrl_d   = '0;
        ex_valid_d  = 1'b0;
        payload_d   = '0;
        stall_cnt_d = stall_cnt_q;

        load_use = ex_valid_q
                 & (ex_ctrl_q[MEMREAD_HI:MEMREAD_LO] != 2'b00)
                 & (payload_q.rt != '0)
                 & bus.id_valid
                 & ((payload_q.rt == bus.id_rs) | (payload_q.rt == bus.id_rt));

        // A flush kills the dependent instruction anyway, so no stall is needed.
        stall  = load_use & ~bus.flush;
        bubble = bus.flush | load_use;

        payload_d.pc4     = bus.id_pc4;
        payload_d.rs_data = bus.id_rs_data;
        payload_d.rt_data = bus.id_rt_data;
        payload_d.imm     = bus.id_imm;
        payload_d.rs      = bus.id_rs;
        payload_d.rt      = bus.id_rt;
        payload_d.rd      = bus.id_rd;
        payload_d.funct   = bus.id_funct;

        // An all-zero control word is a side-effect-free bubble.
        if (!bubble && bus.id_valid) begin
            ex_ctrl_d  = bus.id_ctrl;
            ex_valid_d = 1'b1;
        end

        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Pipeline register and stall counter; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q   <= '0;
            ex_valid_q  <= 1'b0;
            payload_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ex_ctrl_q   <= ex_ctrl_d;
            ex_valid_q  <= ex_valid_d;
            payload_q   <= payload_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_pc4     = payload_q.pc4;
    assign bus.ex_rs_data = payload_q.rs_data;
    assign bus.ex_rt_data = payload_q.rt_data;
    assign bus.ex_imm     = payload_q.imm;
    assign bus.ex_rs      = payload_q.rs;
    assign bus.ex_rt      = payload_q.rt;
    assign bus.ex_rd      = payload_q.rd;
    assign bus.ex_funct   = payload_q.funct;
    assign bus.stall      = stall;
    assign bus.stall_cnt  = stall_cnt_q;
endmodule
